// File: rtl/pokey_pkg.sv
// Shared constants and types for the POKEY bus scheduler.
// Defining POKEY_UNMUTE_EN adds the UNMUTE sequencer state.
package pokey_pkg;

  localparam logic [3:0] ADDR_AUDC1  = 4'h1;
  localparam logic [3:0] ADDR_AUDC2  = 4'h3;
  localparam logic [3:0] ADDR_AUDC3  = 4'h5;
  localparam logic [3:0] ADDR_AUDC4  = 4'h7;
  localparam logic [3:0] ADDR_AUDCTL = 4'h8;
  localparam logic [3:0] ADDR_SKCTL  = 4'hF;

  localparam int INIT_LEN = 14;
  localparam int MUTE_LEN = 8;
  localparam logic [3:0] INIT_LAST = 4'(INIT_LEN - 1);
  localparam logic [3:0] MUTE_LAST = 4'(MUTE_LEN - 1);

`ifdef POKEY_UNMUTE_EN
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_MUTE, ST_UNMUTE} seq_state_t;
`else
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_MUTE} seq_state_t;
`endif

  // AUDC register k (0..3) lives at the odd addresses 1, 3, 5, 7.
  function automatic logic [3:0] audc_addr(input logic [1:0] k);
    return {1'b0, k, 1'b1};
  endfunction

endpackage

// File: rtl/pokey_seq_rom.sv
// Sequencer table lookup: (mode, index) -> {chip, addr, data}.
// Mute and unmute share one layout; unmute data is substituted by the caller.
module pokey_seq_rom
  import pokey_pkg::*;
#(
  parameter logic [7:0] INIT_AUDCTL = 8'h00,
  parameter logic [7:0] INIT_SKCTL  = 8'h03
) (
  input  seq_state_t  mode,
  input  logic [3:0]  idx,
  output logic        chip,
  output logic [3:0]  addr,
  output logic [7:0]  data
);

  logic [3:0] j;

  always_comb begin
    chip = 1'b0;
    addr = 4'h0;
    data = 8'h00;
    j    = 4'h0;
    if (mode == ST_INIT) begin
      // Seven entries per chip: AUDCTL, SKCTL reset, SKCTL run, four AUDC clears.
      chip = (idx >= 4'd7);
      j    = chip ? (idx - 4'd7) : idx;
      case (j)
        4'd0: begin
          addr = ADDR_AUDCTL;
          data = INIT_AUDCTL;
        end
        4'd1: addr = ADDR_SKCTL;
        4'd2: begin
          addr = ADDR_SKCTL;
          data = INIT_SKCTL;
        end
        default: addr = audc_addr(2'(j - 4'd3));
      endcase
    end else begin
      chip = idx[2];
      addr = audc_addr(idx[1:0]);
    end
  end

endmodule

// File: rtl/pokey_bus_sched.sv
// Shares the two POKEY register ports between the CPU (always first) and the
// init/mute write sequencer. POKEY_UNMUTE_EN adds shadow AUDC replay.
module pokey_bus_sched
  import pokey_pkg::*;
#(
  parameter logic [7:0] INIT_AUDCTL = 8'h00,
  parameter logic [7:0] INIT_SKCTL  = 8'h03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce2Hd,
  input  logic        cpu_cs,
  input  logic        cpu_sel,
  input  logic [3:0]  cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic [7:0]  pk_rdata0,
  input  logic [7:0]  pk_rdata1,
  input  logic        mute_req,
`ifdef POKEY_UNMUTE_EN
  input  logic        unmute_req,
`endif
  output logic [1:0]  pk_cs,
  output logic [3:0]  pk_addr,
  output logic        pk_we,
  output logic [7:0]  pk_wdata,
  output logic        init_done,
  output logic        seq_busy
);

  seq_state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       init_done_q, init_done_d;
  logic       mute_prev_q, mute_pend_q, mute_pend_d, mute_edge, mute_take;
  logic       rom_chip;
  logic [3:0] rom_addr;
  logic [7:0] rom_data, seq_data;
  logic       seq_own;

  pokey_seq_rom #(
    .INIT_AUDCTL(INIT_AUDCTL),
    .INIT_SKCTL (INIT_SKCTL)
  ) u_rom (
    .mode(state_q),
    .idx (idx_q),
    .chip(rom_chip),
    .addr(rom_addr),
    .data(rom_data)
  );

`ifdef POKEY_UNMUTE_EN
  logic [7:0] shadow_q [8];
  logic       shadow_wr;
  logic       unmute_prev_q, unmute_pend_q, unmute_pend_d, unmute_edge, unmute_take;

  assign shadow_wr   = ce2Hd & cpu_cs & cpu_we & ~cpu_addr[3] & cpu_addr[0];
  assign unmute_edge = unmute_req & ~unmute_prev_q;
  assign seq_data    = (state_q == ST_UNMUTE) ? shadow_q[idx_q[2:0]] : rom_data;

  // Shadow slot {chip, AUDC k} matches the mute-table entry index.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) shadow_q[i] <= 8'h00;
    end else if (shadow_wr) begin
      shadow_q[{cpu_sel, cpu_addr[2:1]}] <= cpu_wdata;
    end
  end
`else
  assign seq_data = rom_data;
`endif

  assign mute_edge = mute_req & ~mute_prev_q;
  assign seq_busy  = (state_q != ST_IDLE);
  assign init_done = init_done_q;
  assign cpu_rdata = cpu_sel ? pk_rdata1 : pk_rdata0;
  assign seq_own   = ce2Hd & ~cpu_cs & seq_busy & ~reset;

  always_comb begin
    pk_cs    = 2'b00;
    pk_addr  = 4'h0;
    pk_we    = 1'b0;
    pk_wdata = 8'h00;
    if (cpu_cs) begin
      pk_cs    = ce2Hd ? (cpu_sel ? 2'b10 : 2'b01) : 2'b00;
      pk_addr  = cpu_addr;
      pk_we    = cpu_we;
      pk_wdata = cpu_wdata;
    end else if (seq_own) begin
      pk_cs    = rom_chip ? 2'b10 : 2'b01;
      pk_addr  = rom_addr;
      pk_we    = 1'b1;
      pk_wdata = seq_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    mute_take   = 1'b0;
`ifdef POKEY_UNMUTE_EN
    unmute_take = 1'b0;
`endif
    if (ce2Hd) begin
      case (state_q)
        ST_INIT: begin
          if (seq_own) begin
            if (idx_q == INIT_LAST) begin
              state_d     = ST_IDLE;
              idx_d       = 4'd0;
              init_done_d = 1'b1;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        ST_IDLE: begin
          if (mute_pend_q) begin
            state_d   = ST_MUTE;
            idx_d     = 4'd0;
            mute_take = 1'b1;
          end
`ifdef POKEY_UNMUTE_EN
          else if (unmute_pend_q) begin
            state_d     = ST_UNMUTE;
            idx_d       = 4'd0;
            unmute_take = 1'b1;
          end
`endif
        end
        default: begin
          // MUTE and UNMUTE walk the same 8-entry layout; a fresh mute restarts it.
          if (mute_pend_q) begin
            state_d   = ST_MUTE;
            idx_d     = 4'd0;
            mute_take = 1'b1;
          end
`ifdef POKEY_UNMUTE_EN
          else if (state_q == ST_UNMUTE && unmute_pend_q) begin
            idx_d       = 4'd0;
            unmute_take = 1'b1;
          end
`endif
          else if (seq_own) begin
            if (idx_q == MUTE_LAST) begin
              state_d = ST_IDLE;
              idx_d   = 4'd0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
      endcase
    end
    mute_pend_d = (mute_pend_q & ~mute_take) | mute_edge;
`ifdef POKEY_UNMUTE_EN
    unmute_pend_d = (unmute_pend_q & ~unmute_take) | unmute_edge;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      idx_q       <= 4'd0;
      init_done_q <= 1'b0;
      mute_prev_q <= 1'b0;
      mute_pend_q <= 1'b0;
`ifdef POKEY_UNMUTE_EN
      unmute_prev_q <= 1'b0;
      unmute_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      mute_prev_q <= mute_req;
      mute_pend_q <= mute_pend_d;
`ifdef POKEY_UNMUTE_EN
      unmute_prev_q <= unmute_req;
      unmute_pend_q <= unmute_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_pokey_bus_sched.sv
// Directed bench for pokey_bus_sched: init table, CPU preemption, mute,
// reset mid-sequence, and (with POKEY_UNMUTE_EN) shadow replay.
module tb_pokey_bus_sched;

  logic       clk = 1'b0;
  logic       reset, ce2Hd, cpu_cs, cpu_sel, cpu_we, mute_req;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata, pk_rdata0, pk_rdata1;
  logic [1:0] pk_cs;
  logic [3:0] pk_addr;
  logic       pk_we;
  logic [7:0] pk_wdata;
  logic       init_done, seq_busy;
`ifdef POKEY_UNMUTE_EN
  logic       unmute_req;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [14:0] obs;

  // {chip, addr, data} per entry, hand-written from the table description.
  logic [15:0] init_tbl [14] = '{16'h0800, 16'h0F00, 16'h0F03, 16'h0100, 16'h0300,
                                 16'h0500, 16'h0700, 16'h1800, 16'h1F00, 16'h1F03,
                                 16'h1100, 16'h1300, 16'h1500, 16'h1700};
  logic [15:0] mute_tbl [8]  = '{16'h0100, 16'h0300, 16'h0500, 16'h0700,
                                 16'h1100, 16'h1300, 16'h1500, 16'h1700};

  always #5 clk = ~clk;

  pokey_bus_sched dut (
    .clk(clk), .reset(reset), .ce2Hd(ce2Hd),
    .cpu_cs(cpu_cs), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .pk_rdata0(pk_rdata0), .pk_rdata1(pk_rdata1), .mute_req(mute_req),
`ifdef POKEY_UNMUTE_EN
    .unmute_req(unmute_req),
`endif
    .pk_cs(pk_cs), .pk_addr(pk_addr), .pk_we(pk_we), .pk_wdata(pk_wdata),
    .init_done(init_done), .seq_busy(seq_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [14:0] seq_word(input logic [15:0] e);
    return {(e[12] ? 2'b10 : 2'b01), e[11:8], 1'b1, e[7:0]};
  endfunction

  // One bus slot: ce2Hd high for one clk, then three idle clks.
  task automatic do_slot(output logic [14:0] o);
    ce2Hd = 1'b1;
    @(negedge clk);
    o = {pk_cs, pk_addr, pk_we, pk_wdata};
    @(posedge clk); #1;
    ce2Hd = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_mute();
    mute_req = 1'b1;
    @(posedge clk); #1;
    mute_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic cpu_idle();
    cpu_cs = 1'b0; cpu_sel = 1'b0; cpu_addr = 4'h0; cpu_we = 1'b0; cpu_wdata = 8'h00;
  endtask

  initial begin
    int k;
    cpu_idle();
    mute_req = 1'b0;
`ifdef POKEY_UNMUTE_EN
    unmute_req = 1'b0;
`endif
    pk_rdata0 = 8'h11;
    pk_rdata1 = 8'h22;
    reset = 1'b1;
    ce2Hd = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_pk_cs", 32'(pk_cs), 32'h0);
    check_eq("rst_init_done", 32'(init_done), 32'h0);
    check_eq("rst_seq_busy", 32'(seq_busy), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    ce2Hd = 1'b0;

    // Plain init: 14 entries in table order.
    for (int i = 0; i < 14; i++) begin
      do_slot(obs);
      check_eq($sformatf("init%0d", i), 32'(obs), 32'(seq_word(init_tbl[i])));
      if (i == 12) check_eq("init_done_13", 32'(init_done), 32'h0);
    end
    check_eq("init_done_14", 32'(init_done), 32'h1);
    check_eq("busy_after_init", 32'(seq_busy), 32'h0);

    cpu_sel = 1'b0; #1;
    check_eq("rdata0", 32'(cpu_rdata), 32'h11);
    cpu_sel = 1'b1; #1;
    check_eq("rdata1", 32'(cpu_rdata), 32'h22);
    cpu_sel = 1'b0;

    // CPU steals the third init slot; entry 2 retried next slot.
    do_reset();
    k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s == 2) begin
        cpu_cs = 1'b1; cpu_sel = 1'b1; cpu_addr = 4'h2; cpu_we = 1'b1; cpu_wdata = 8'h5A;
        do_slot(obs);
        cpu_idle();
        check_eq("cpu_steal", 32'(obs), 32'({2'b10, 4'h2, 1'b1, 8'h5A}));
      end else begin
        do_slot(obs);
        check_eq($sformatf("retry_init%0d", k), 32'(obs), 32'(seq_word(init_tbl[k])));
        k++;
      end
      if (s == 13) check_eq("init_done_s14", 32'(init_done), 32'h0);
    end
    check_eq("init_done_s15", 32'(init_done), 32'h1);

    // Mute: one slot to enter MUTE, then 8 writes.
    pulse_mute();
    do_slot(obs);
    check_eq("mute_enter_slot", 32'(obs), 32'h0);
    check_eq("mute_busy_start", 32'(seq_busy), 32'h1);
    for (int i = 0; i < 8; i++) begin
      do_slot(obs);
      check_eq($sformatf("mute%0d", i), 32'(obs), 32'(seq_word(mute_tbl[i])));
      if (i < 7) check_eq($sformatf("mute_busy%0d", i), 32'(seq_busy), 32'h1);
    end
    check_eq("mute_busy_end", 32'(seq_busy), 32'h0);

    // CPU holds five slots in the middle of a mute.
    pulse_mute();
    do_slot(obs);
    for (int i = 0; i < 2; i++) begin
      do_slot(obs);
      check_eq($sformatf("hold_mute%0d", i), 32'(obs), 32'(seq_word(mute_tbl[i])));
    end
    for (int s = 0; s < 5; s++) begin
      cpu_cs = 1'b1; cpu_sel = 1'b0; cpu_addr = 4'h0; cpu_we = 1'b0; cpu_wdata = 8'h00;
      do_slot(obs);
      check_eq($sformatf("hold_cpu%0d", s), 32'(obs), 32'({2'b01, 4'h0, 1'b0, 8'h00}));
    end
    cpu_idle();
    for (int i = 2; i < 8; i++) begin
      do_slot(obs);
      check_eq($sformatf("hold_mute%0d", i), 32'(obs), 32'(seq_word(mute_tbl[i])));
    end
    check_eq("hold_busy_end", 32'(seq_busy), 32'h0);

    // Reset in the middle of a mute restarts init.
    pulse_mute();
    do_slot(obs);
    for (int i = 0; i < 3; i++) do_slot(obs);
    do_reset();
    check_eq("midreset_init_done", 32'(init_done), 32'h0);
    do_slot(obs);
    check_eq("midreset_first", 32'(obs), 32'(seq_word(init_tbl[0])));

`ifdef POKEY_UNMUTE_EN
    for (int i = 1; i < 14; i++) do_slot(obs);
    check_eq("un_init_done", 32'(init_done), 32'h1);
    cpu_cs = 1'b1; cpu_sel = 1'b0; cpu_addr = 4'h1; cpu_we = 1'b1; cpu_wdata = 8'hA4;
    do_slot(obs);
    cpu_idle();
    check_eq("un_cpu_wr", 32'(obs), 32'({2'b01, 4'h1, 1'b1, 8'hA4}));
    pulse_mute();
    do_slot(obs);
    for (int i = 0; i < 8; i++) do_slot(obs);
    check_eq("un_mute_done", 32'(seq_busy), 32'h0);
    unmute_req = 1'b1;
    @(posedge clk); #1;
    unmute_req = 1'b0;
    do_slot(obs);
    for (int i = 0; i < 8; i++) begin
      do_slot(obs);
      check_eq($sformatf("unmute%0d", i), 32'(obs),
               32'(seq_word(mute_tbl[i] | ((i == 0) ? 16'h00A4 : 16'h0000))));
    end
    check_eq("unmute_busy_end", 32'(seq_busy), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pokey_bus_sched.md
Name: pokey_bus_sched

Overview:
- Slot scheduler sharing the register ports of the two sound POKEYs (chip 0 = DIP/switch chip, chip 1 = second chip) between the CPU and an internal hardware write sequencer.
- The sequencer programs both chips after reset (init table) and silences all eight channels on request (mute).
- Sits between CPU address decode and the POKEY instances in the audio output block. The CPU always wins a slot; the sequencer only uses slots the CPU leaves idle.

Parameters:
- INIT_AUDCTL, 8'h00, value written to AUDCTL (addr 8) during init.
- INIT_SKCTL, 8'h03, final SKCTL (addr F) value during init. SKCTL is written 8'h00 first, then this value.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce2Hd  in  1  POKEY clock enable; one ce2Hd cycle = one bus slot.
- cpu_cs  in  1  CPU selects a POKEY this slot.
- cpu_sel  in  1  0 = chip 0, 1 = chip 1.
- cpu_addr  in  4  POKEY register address.
- cpu_we  in  1  CPU write strobe.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  read data returned to the CPU.
- pk_rdata0  in  8  read data from chip 0.
- pk_rdata1  in  8  read data from chip 1.
- mute_req  in  1  rising edge requests a mute sequence.
- pk_cs  out  2  per-chip select, one-hot or zero.
- pk_addr  out  4  POKEY address.
- pk_we  out  1  POKEY write enable.
- pk_wdata  out  8  POKEY write data.
- init_done  out  1  init table fully written.
- seq_busy  out  1  sequencer holds a pending entry.

Behaviour:
- Sequencer FSM states: INIT, IDLE, MUTE. Add UNMUTE when POKEY_UNMUTE_EN is defined. Reset enters INIT with index 0.
- Reset values:
  - init_done = 0, seq_busy = 1.
  - All sequencer registers cleared.
  - pk_* outputs follow the CPU mux, so they are 0 while cpu_cs = 0.
- Init table, per chip, in order:
  - 8 <- INIT_AUDCTL
  - F <- 00
  - F <- INIT_SKCTL
  - 1 <- 00, 3 <- 00, 5 <- 00, 7 <- 00
  - Chip 0 is written fully, then chip 1: 14 entries total.
- Mute table: AUDC 1, 3, 5, 7 <- 00, chip 0 then chip 1: 8 entries.
- Slot ownership is decided combinationally within the ce2Hd cycle:
  - If cpu_cs = 1, the CPU owns the slot. pk_cs[cpu_sel] = 1, and pk_addr/pk_we/pk_wdata = CPU inputs, combinational passthrough with zero latency.
  - If cpu_cs = 0 and the sequencer has a pending entry, the sequencer owns the slot. pk_we = 1, and pk_cs/pk_addr/pk_wdata come from registered entry fields.
  - Otherwise pk_cs = 0.
- The sequencer index advances only on a clk edge with ce2Hd = 1 in which the sequencer owned the slot. A CPU-owned slot leaves the index unchanged, so the entry is retried on the next slot. Entries are never dropped or reordered.
- With ce2Hd = 0, pk_cs = 0 and no state changes, except mute edge capture.
- init_done rises on the edge that commits the last init entry. After that, the FSM goes INIT -> IDLE and seq_busy falls.
- Mute requests:
  - A mute_req rising edge is latched on any clk, as a sticky pending flag.
  - Pending mute is serviced IDLE -> MUTE at the next ce2Hd edge. It is deferred until init_done if it arrives during INIT.
  - A second edge during MUTE restarts the index at 0.
  - MUTE -> IDLE after the 8th committed entry.
- cpu_rdata = cpu_sel ? pk_rdata1 : pk_rdata0. This is combinational and independent of the sequencer.
- reset mid-sequence abandons the current entry and restarts INIT at index 0 on the next clk.

Optional Feature:
- Macro: POKEY_UNMUTE_EN.
- When defined:
  - Shadow registers hold the last CPU-written AUDC1/3/5/7 per chip (8 x 8 bits, reset 00), updated on CPU-owned write slots to addresses 1, 3, 5, 7.
  - Adds an input unmute_req. Its rising edge runs the UNMUTE state, which replays the 8 shadow values in mute-table order, with the same yield and retry rules.
  - If mute and unmute are both pending, mute wins.
- When undefined: no shadows, no unmute_req port, no UNMUTE state.

Decomposition:
- Shared package pokey_pkg:
  - Register address constants (AUDC1 = 1, AUDC2 = 3, AUDC3 = 5, AUDC4 = 7, AUDCTL = 8, SKCTL = F).
  - Sequencer state typedef.
  - Init and mute table lengths (14, 8).
- Sub-module pokey_seq_rom: combinational table lookup, mode + index -> {chip, addr, data}.

Test Plan:
- Reset, no CPU traffic, ce2Hd every 4th clk -> 14 sequencer writes in table order; first write is chip 0 addr 8 data 00, last is chip 1 addr 7 data 00; init_done = 1 after the 14th ce edge.
- CPU write chip 1 addr 2 data 5A in the 3rd init slot -> pk_cs = 2'b10, pk_wdata = 5A that slot; the SKCTL=03 entry is written the next slot instead; init completes on the 15th ce edge.
- After init, mute_req pulse -> 8 writes of 00 to addrs 1, 3, 5, 7 on chip 0, then chip 1; seq_busy high throughout, then low.
- cpu_cs held high for 5 consecutive slots during MUTE -> no sequencer writes in those slots; the mute index is unchanged, then resumes.
- reset asserted mid-MUTE -> next sequencer write is chip 0 addr 8 data INIT_AUDCTL; init_done = 0.
- POKEY_UNMUTE_EN defined: CPU writes chip 0 AUDC1 = A4, then mute, then unmute_req -> replay writes chip 0 addr 1 data A4; other entries 00.
